regfile_param_clear: RTL and testbench

//  Parametrised 2-read/1-write register file for the datapath. Replaces the fixed 32x32 file.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_clear_fsm.sv | 84 ++++++++
 rtl/regfile_param_clear.sv | 135 +++++++++++++
 tb/tb_regfile_param_clear.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register file and its soft-clear
// engine. Decode and writeback import the default widths from here so the
// whole datapath agrees on register and address sizes.
//
// Contents:
//   REGFILE_DATA_W  default register width
//   REGFILE_ADDR_W  default address width (DEPTH = 2**ADDR_W)
//   REGFILE_DBG_W   default width of the board-display debug taps
//   clr_state_t     soft-clear FSM state encoding
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int unsigned REGFILE_DATA_W = 32;
   localparam int unsigned REGFILE_ADDR_W = 5;
   localparam int unsigned REGFILE_DBG_W  = 8;

   // CLR_RUN is the CLEAR state: one entry is zeroed per cycle.
   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_RUN,
      CLR_DONE
   } clr_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Sequential soft-clear engine. On a clr_req seen in IDLE it walks a pointer
// over every entry of the register file, one entry per cycle, then raises a
// single-cycle done pulse and returns to IDLE. Requests arriving while the
// engine is busy or done are dropped, not queued.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous active-low reset; aborts a clear in progress
//   clr_req   in   soft-clear request, only looked at in IDLE
//   clr_en    out  zero the entry at clr_addr on this edge
//   clr_addr  out  entry being cleared this cycle
//   clr_busy  out  high for the whole clear walk
//   clr_done  out  one-cycle pulse after the last entry is cleared
// -----------------------------------------------------------------------------
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              clr_busy,
   output logic              clr_done
);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CLR_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clr_en   = 1'b0;
      clr_busy = 1'b0;
      clr_done = 1'b0;

      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_RUN;
               ptr_d   = '0;
            end
         end

         CLR_RUN: begin
            clr_en   = 1'b1;
            clr_busy = 1'b1;
            // The pointer wraps back to 0 on its own after the last entry.
            ptr_d    = ptr_q + ADDR_W'(1);
            if (&ptr_q) begin
               state_d = CLR_DONE;
            end
         end

         CLR_DONE: begin
            clr_done = 1'b1;
            state_d  = CLR_IDLE;
         end

         default: begin
            state_d = CLR_IDLE;
         end
      endcase
   end

   assign clr_addr = ptr_q;

endmodule : regfile_clear_fsm

// File: rtl/regfile_param_clear.sv
// -----------------------------------------------------------------------------
// regfile_param_clear
// Parametrised 2-read/1-write register file sitting between decode and
// writeback. Both read ports are registered (data visible the cycle after the
// address), with optional forwarding of a same-cycle accepted write. Entry 0
// can be hardwired to zero. A soft-clear engine zeroes the whole file one
// entry per cycle; writes arriving during the walk are refused and flagged.
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   ZERO_REG  1: entry 0 reads 0 and ignores writes
//   BYPASS    1: accepted write forwards to a same-cycle read of that address
//   DBG_W     width of the debug taps (must not exceed DATA_W)
//
// Ports:
//   clk                 in   clock
//   rst                 in   synchronous active-low reset
//   ra1, ra2            in   read addresses
//   wa3, we3, wd3       in   write address / enable / data
//   clr_req             in   soft-clear request
//   rd1, rd2            out  registered read data
//   saida_rd1/2         out  low DBG_W bits of rd1/rd2 for board display
//   clr_busy, clr_done  out  soft-clear status
//   wr_drop             out  registered pulse: a write was refused by a clear
// -----------------------------------------------------------------------------
module regfile_param_clear
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = REGFILE_DATA_W,
   parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned DBG_W    = REGFILE_DBG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] wa3,
   input  logic              we3,
   input  logic [DATA_W-1:0] wd3,
   input  logic              clr_req,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DBG_W-1:0]  saida_rd1,
   output logic [DBG_W-1:0]  saida_rd2,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;
   logic              wr_drop_q, wr_drop_d;

   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              wa3_is_r0;
   logic              acc;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_en   (clr_en),
      .clr_addr (clr_addr),
      .clr_busy (clr_busy),
      .clr_done (clr_done)
   );

   // A write to a hardwired r0 is silently discarded: neither stored nor dropped.
   assign wa3_is_r0 = ZERO_REG && (wa3 == '0);
   assign acc       = we3 && !clr_busy && !wa3_is_r0;

   // Storage update: the clear walk owns the write port while it runs.
   always_comb begin
      mem_d = mem_q;
      if (clr_en) begin
         mem_d[clr_addr] = '0;
      end else if (acc) begin
         mem_d[wa3] = wd3;
      end
   end

   // Read values for the output registers. The clear is deliberately not
   // forwarded, so reading the entry being cleared returns its old contents.
   always_comb begin
      rd1_d = mem_q[ra1];
      if (BYPASS && acc && (wa3 == ra1)) begin
         rd1_d = wd3;
      end
      if (ZERO_REG && (ra1 == '0)) begin
         rd1_d = '0;
      end

      rd2_d = mem_q[ra2];
      if (BYPASS && acc && (wa3 == ra2)) begin
         rd2_d = wd3;
      end
      if (ZERO_REG && (ra2 == '0)) begin
         rd2_d = '0;
      end
   end

   assign wr_drop_d = we3 && clr_busy && !wa3_is_r0;

   // NOTE: the storage array is reset too, since reset must leave every entry reading 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q     <= '{default: '0};
         rd1_q     <= '0;
         rd2_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   assign rd1       = rd1_q;
   assign rd2       = rd2_q;
   assign saida_rd1 = rd1_q[DBG_W-1:0];
   assign saida_rd2 = rd2_q[DBG_W-1:0];
   assign wr_drop   = wr_drop_q;

endmodule : regfile_param_clear

// File: tb/tb_regfile_param_clear.sv
// -----------------------------------------------------------------------------
// tb_regfile_param_clear
// Directed bench for regfile_param_clear. Two instances share the stimulus:
// u_dut uses the defaults (ZERO_REG=1, BYPASS=1), u_nb is built with
// ZERO_REG=0, BYPASS=0 so the alternative read/zero behaviour is covered.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_regfile_param_clear;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DBG_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] ra1, ra2, wa3;
   logic              we3;
   logic [DATA_W-1:0] wd3;
   logic              clr_req;

   logic [DATA_W-1:0] rd1, rd2;
   logic [DBG_W-1:0]  saida_rd1, saida_rd2;
   logic              clr_busy, clr_done, wr_drop;

   logic [DATA_W-1:0] nb_rd1, nb_rd2;
   logic [DBG_W-1:0]  nb_saida_rd1, nb_saida_rd2;
   logic              nb_clr_busy, nb_clr_done, nb_wr_drop;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_param_clear u_dut (
      .clk       (clk),
      .rst       (rst),
      .ra1       (ra1),
      .ra2       (ra2),
      .wa3       (wa3),
      .we3       (we3),
      .wd3       (wd3),
      .clr_req   (clr_req),
      .rd1       (rd1),
      .rd2       (rd2),
      .saida_rd1 (saida_rd1),
      .saida_rd2 (saida_rd2),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .wr_drop   (wr_drop)
   );

   regfile_param_clear #(
      .ZERO_REG (1'b0),
      .BYPASS   (1'b0)
   ) u_nb (
      .clk       (clk),
      .rst       (rst),
      .ra1       (ra1),
      .ra2       (ra2),
      .wa3       (wa3),
      .we3       (we3),
      .wd3       (wd3),
      .clr_req   (clr_req),
      .rd1       (nb_rd1),
      .rd2       (nb_rd2),
      .saida_rd1 (nb_saida_rd1),
      .saida_rd2 (nb_saida_rd2),
      .clr_busy  (nb_clr_busy),
      .clr_done  (nb_clr_done),
      .wr_drop   (nb_wr_drop)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h55; ra1 = '0; ra2 = '0; clr_req = 1'b0;
      step();
      we3 = 1'b0; ra1 = 5'd5;
      step();
      checks++; if (rd1 !== 32'h55) begin errors++; $display("FAIL reset_prewrite_rd1: got %h want %h", rd1, 32'h55); end
      rst = 1'b0;
      step();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want %h", rd1, 32'h0); end
      checks++; if (nb_rd1 !== 32'h0) begin errors++; $display("FAIL reset_nb_rd1: got %h want %h", nb_rd1, 32'h0); end
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b want 0", clr_done); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
      rst = 1'b1;
      step();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_mem_r5: got %h want %h", rd1, 32'h0); end
      checks++; if (nb_rd1 !== 32'h0) begin errors++; $display("FAIL reset_nb_mem_r5: got %h want %h", nb_rd1, 32'h0); end
   endtask

   task automatic test_basic();
      we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hDEADBEEF; ra1 = '0; ra2 = '0;
      step();
      we3 = 1'b0; ra1 = 5'd7; ra2 = 5'd7;
      step();
      checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd1: got %h want %h", rd1, 32'hDEADBEEF); end
      checks++; if (saida_rd1 !== 8'hEF) begin errors++; $display("FAIL basic_saida_rd1: got %h want %h", saida_rd1, 8'hEF); end
      checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd2: got %h want %h", rd2, 32'hDEADBEEF); end
      checks++; if (saida_rd2 !== 8'hEF) begin errors++; $display("FAIL basic_saida_rd2: got %h want %h", saida_rd2, 8'hEF); end
      checks++; if (nb_rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_nb_rd1: got %h want %h", nb_rd1, 32'hDEADBEEF); end
   endtask

   task automatic test_bypass();
      we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hAAAA; ra1 = '0; ra2 = '0;
      step();
      wd3 = 32'h1234; ra2 = 5'd3;
      step();
      checks++; if (rd2 !== 32'h1234) begin errors++; $display("FAIL bypass_rd2: got %h want %h", rd2, 32'h1234); end
      checks++; if (nb_rd2 !== 32'hAAAA) begin errors++; $display("FAIL bypass_nb_rd2_old: got %h want %h", nb_rd2, 32'hAAAA); end
      we3 = 1'b0;
      step();
      checks++; if (rd2 !== 32'h1234) begin errors++; $display("FAIL bypass_rd2_after: got %h want %h", rd2, 32'h1234); end
      checks++; if (nb_rd2 !== 32'h1234) begin errors++; $display("FAIL bypass_nb_rd2_after: got %h want %h", nb_rd2, 32'h1234); end
   endtask

   task automatic test_zero_reg();
      we3 = 1'b1; wa3 = '0; wd3 = 32'hFFFFFFFF; ra1 = '0; ra2 = '0;
      step();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd1_same: got %h want %h", rd1, 32'h0); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL zero_wr_drop: got %b want 0", wr_drop); end
      checks++; if (nb_rd1 !== 32'h0) begin errors++; $display("FAIL zero_nb_rd1_old: got %h want %h", nb_rd1, 32'h0); end
      we3 = 1'b0;
      step();
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd1: got %h want %h", rd1, 32'h0); end
      checks++; if (nb_rd1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_nb_rd1: got %h want %h", nb_rd1, 32'hFFFFFFFF); end
   endtask

   task automatic test_clear();
      int          busy_cnt;
      bit          done_seen;
      logic [31:0] exp;
      for (int i = 1; i < 32; i++) begin
         we3 = 1'b1; wa3 = ADDR_W'(i); wd3 = DATA_W'(i);
         step();
      end
      we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd3;
      step();
      checks++; if (rd1 !== 32'd31) begin errors++; $display("FAIL fill_r31: got %h want %h", rd1, 32'd31); end
      checks++; if (rd2 !== 32'd3) begin errors++; $display("FAIL fill_r3: got %h want %h", rd2, 32'd3); end

      ra1 = '0; ra2 = '0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      busy_cnt = 0; done_seen = 1'b0;
      for (int k = 1; k <= 40 && !done_seen; k++) begin
         if (clr_done) begin
            done_seen = 1'b1;
         end else begin
            if (clr_busy) busy_cnt++;
            we3 = 1'b0; clr_req = 1'b0;
            if (k == 4) begin we3 = 1'b1; wa3 = 5'd1; wd3 = 32'hBAD; ra1 = 5'd10; ra2 = 5'd3; end
            if (k == 6) clr_req = 1'b1;
            step();
            if (k == 4) begin
               checks++; if (rd1 !== 32'd10) begin errors++; $display("FAIL clear_read_old: got %h want %h", rd1, 32'd10); end
               checks++; if (rd2 !== 32'd3) begin errors++; $display("FAIL clear_read_no_bypass: got %h want %h", rd2, 32'd3); end
               checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL clear_wr_drop: got %b want 1", wr_drop); end
               checks++; if (nb_wr_drop !== 1'b1) begin errors++; $display("FAIL clear_nb_wr_drop: got %b want 1", nb_wr_drop); end
            end
            if (k == 5) begin
               checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL clear_wr_drop_pulse: got %b want 0", wr_drop); end
            end
         end
      end
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL clear_done_seen: got %b want 1 (timeout)", done_seen); end
      checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL clear_busy_cycles: got %0d want 32", busy_cnt); end
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_in_done: got %b want 0", clr_busy); end

      // DONE cycle: write is accepted, a new request is ignored.
      we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h99; clr_req = 1'b1;
      step();
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL clear_done_one_cycle: got %b want 0", clr_done); end
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_req_in_done_ignored: got %b want 0", clr_busy); end
      we3 = 1'b0; clr_req = 1'b0;
      step();
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_req_not_queued: got %b want 0", clr_busy); end

      for (int i = 0; i < 32; i++) begin
         ra1 = ADDR_W'(i); ra2 = ADDR_W'(i);
         step();
         exp = (i == 9) ? 32'h99 : 32'h0;
         checks++; if (rd1 !== exp) begin errors++; $display("FAIL clear_entry_%0d: got %h want %h", i, rd1, exp); end
         checks++; if (nb_rd1 !== exp) begin errors++; $display("FAIL clear_nb_entry_%0d: got %h want %h", i, nb_rd1, exp); end
      end
   endtask

   task automatic test_abort();
      int busy_cnt;
      bit done_seen;
      we3 = 1'b1; wa3 = '0; wd3 = 32'hF0;
      step();
      wa3 = 5'd20; wd3 = 32'h20;
      step();
      we3 = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int k = 1; k < 10; k++) step();
      checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", clr_busy); end
      rst = 1'b0;
      step();
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", clr_busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", clr_done); end
      rst = 1'b1; ra1 = 5'd20; ra2 = '0;
      step();
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", clr_done); end
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", clr_busy); end
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL abort_r20: got %h want %h", rd1, 32'h0); end
      checks++; if (nb_rd2 !== 32'h0) begin errors++; $display("FAIL abort_nb_r0: got %h want %h", nb_rd2, 32'h0); end

      // Restart: entry 0 must be the first one cleared.
      we3 = 1'b1; wa3 = '0; wd3 = 32'hF0;
      step();
      wa3 = 5'd25; wd3 = 32'h25;
      step();
      we3 = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      busy_cnt = 0; done_seen = 1'b0;
      for (int k = 1; k <= 40 && !done_seen; k++) begin
         if (clr_done) begin
            done_seen = 1'b1;
         end else begin
            if (clr_busy) busy_cnt++;
            if (k == 2) begin ra1 = '0; ra2 = 5'd25; end
            step();
            if (k == 2) begin
               checks++; if (nb_rd1 !== 32'h0) begin errors++; $display("FAIL restart_ptr0: got %h want %h", nb_rd1, 32'h0); end
               checks++; if (rd2 !== 32'h25) begin errors++; $display("FAIL restart_r25_old: got %h want %h", rd2, 32'h25); end
            end
         end
      end
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL restart_done_seen: got %b want 1 (timeout)", done_seen); end
      checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL restart_busy_cycles: got %0d want 32", busy_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_prev, exp_cur;
      we3 = 1'b0; clr_req = 1'b0;
      step();
      for (int i = 1; i <= 4; i++) begin
         we3 = 1'b1; wa3 = ADDR_W'(i); wd3 = i * 32'h111;
         ra1 = ADDR_W'(i - 1); ra2 = ADDR_W'(i);
         step();
         exp_prev = (i - 1) * 32'h111;
         exp_cur  = i * 32'h111;
         checks++; if (rd1 !== exp_prev) begin errors++; $display("FAIL b2b_rd1_%0d: got %h want %h", i, rd1, exp_prev); end
         checks++; if (rd2 !== exp_cur) begin errors++; $display("FAIL b2b_rd2_%0d: got %h want %h", i, rd2, exp_cur); end
         checks++; if (nb_rd1 !== exp_prev) begin errors++; $display("FAIL b2b_nb_rd1_%0d: got %h want %h", i, nb_rd1, exp_prev); end
         checks++; if (nb_rd2 !== 32'h0) begin errors++; $display("FAIL b2b_nb_rd2_%0d: got %h want %h", i, nb_rd2, 32'h0); end
      end
      we3 = 1'b0; ra1 = 5'd4;
      step();
      checks++; if (rd1 !== 32'h444) begin errors++; $display("FAIL b2b_final: got %h want %h", rd1, 32'h444); end
   endtask

   initial begin
      rst = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; we3 = 1'b0; wd3 = '0; clr_req = 1'b0;
      step();
      step();
      test_reset();
      test_basic();
      test_bypass();
      test_zero_reg();
      test_clear();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 ns");
      $fatal(1);
   end

endmodule : tb_regfile_param_clear
